// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing MIPS HI/LO.
//            Borrows the shared 32-bit ALU (ADD/SUB only, one op per
//            iteration) while the pipeline is stalled on busy.
// Ports    : clk, reset       - clock (rising edge), synchronous active-high
//            start, op        - launch request and opcode (00 MULT, 01 MULTU,
//                               10 DIV, 11 DIVU), sampled only when idle
//            rs_val, rt_val   - multiplicand/dividend, multiplier/divisor
//            busy, done       - sequencer active / one-cycle completion pulse
//            div_by_zero      - divide by zero flag, qualified by done
//            hi, lo           - HI/LO results, held until the next completion
//            alu_own          - sequencer drives the ALU operands this cycle
//            alu_a, alu_b,
//            alu_control      - ALU operands and function select
//            alu_result       - combinational ALU result
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF,
  parameter int          ITERS   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREP   = 3'd1;
  localparam logic [2:0] S_MUL_IT = 3'd2;
  localparam logic [2:0] S_DIV_IT = 3'd3;
  localparam logic [2:0] S_FIX    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rs_q, rs_d;
  logic [31:0] rt_q, rt_d;
  // opb: multiplicand (mult) or divisor (div)
  logic [31:0] opb_q, opb_d;
  // acc_hi: partial product high half / remainder
  // acc_lo: multiplier shifting out / dividend shifting into quotient
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [4:0]  count_q, count_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;

  logic        is_signed;
  logic        is_div;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic        carry;
  logic [32:0] rem33;
  logic        no_borrow;
  logic        accept;
  logic [63:0] prod;
  logic [63:0] prod_fix;

  assign is_signed = ~op_q[0];
  assign is_div    = op_q[1];
  assign rs_mag    = (is_signed && rs_q[31]) ? -rs_q : rs_q;
  assign rt_mag    = (is_signed && rt_q[31]) ? -rt_q : rt_q;

  // Carry-out of the 32-bit ADD, reconstructed from the operand and result MSBs.
  assign carry = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_result[31]);

  // Restoring-division step: the shifted remainder is 33 bits wide; if its top
  // bit is set it certainly exceeds the divisor, otherwise no-borrow decides.
  assign rem33     = {acc_hi_q, acc_lo_q[31]};
  assign no_borrow = (alu_a[31] & ~alu_b[31]) | ((alu_a[31] | ~alu_b[31]) & ~alu_result[31]);
  assign accept    = rem33[32] | no_borrow;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'b00;
      rs_q      <= '0;
      rt_q      <= '0;
      opb_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      count_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      opb_q     <= opb_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      count_q   <= count_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_PREP;
      S_PREP: begin
        if (is_div && (rt_q == 32'd0)) state_d = S_DONE;
        else if (is_div)               state_d = S_DIV_IT;
        else                           state_d = S_MUL_IT;
      end
      S_MUL_IT,
      S_DIV_IT: if (count_q == LAST_ITER) state_d = S_FIX;
      S_FIX:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    opb_d     = opb_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    count_d   = count_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          rs_d  = rs_val;
          rt_d  = rt_val;
          dbz_d = 1'b0;
        end
      end
      S_PREP: begin
        count_d   = '0;
        neg_res_d = is_signed & (rs_q[31] ^ rt_q[31]);
        neg_rem_d = is_signed & rs_q[31];
        acc_hi_d  = '0;
        if (is_div && (rt_q == 32'd0)) begin
          // Raw dividend goes to HI, no sign handling.
          hi_d  = rs_q;
          lo_d  = DIV0_LO;
          dbz_d = 1'b1;
        end else if (is_div) begin
          opb_d    = rt_mag;
          acc_lo_d = rs_mag;
        end else begin
          opb_d    = rs_mag;
          acc_lo_d = rt_mag;
        end
      end
      S_MUL_IT: begin
        // {carry, sum, multiplier} shifted right by one
        acc_hi_d = {carry, alu_result[31:1]};
        acc_lo_d = {alu_result[0], acc_lo_q[31:1]};
        count_d  = count_q + 5'd1;
      end
      S_DIV_IT: begin
        acc_hi_d = accept ? alu_result : rem33[31:0];
        acc_lo_d = {acc_lo_q[30:0], accept};
        count_d  = count_q + 5'd1;
      end
      S_FIX: begin
        if (is_div) begin
          lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    alu_own     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    case (state_q)
      S_MUL_IT: begin
        alu_own     = 1'b1;
        alu_a       = acc_hi_q;
        alu_b       = acc_lo_q[0] ? opb_q : 32'd0;
        alu_control = ALU_ADD;
      end
      S_DIV_IT: begin
        alu_own     = 1'b1;
        alu_a       = rem33[31:0];
        alu_b       = opb_q;
        alu_control = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Self-checking bench for muldiv_seq. Models the shared ALU and
//            compares HI/LO, flags, latency and ALU usage against a plain
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared ALU: SUB for 0001, ADD otherwise
  assign alu_result = (alu_control == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo),
    .alu_own     (alu_own),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result)
  );

  // Reference model: MIPS HI/LO from plain 64-bit arithmetic
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mhi, output logic [31:0] mlo, output logic mdbz);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    mdbz = 1'b0;
    mhi  = '0;
    mlo  = '0;
    case (mop)
      2'b00: begin
        p   = 64'(sa * sb);
        mhi = p[63:32];
        mlo = p[31:0];
      end
      2'b01: begin
        p   = {32'd0, a} * {32'd0, b};
        mhi = p[63:32];
        mlo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          mhi  = a;
          mlo  = 32'hFFFF_FFFF;
          mdbz = 1'b1;
        end else if (mop == 2'b10) begin
          sq  = sa / sb;
          sr  = sa % sb;
          mlo = sq[31:0];
          mhi = sr[31:0];
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
    endcase
  endfunction

  // Present start with operands for one cycle; returns just after edge 0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run one operation; report latency (cycle of done, -1 on timeout),
  // results, ALU-owned cycle count and ALU-interface misbehaviour count.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] rh, output logic [31:0] rl,
                        output logic rz, output int its, output int alu_bad);
    logic [3:0] want_ctl;
    want_ctl = o[1] ? 4'b0001 : 4'b0000;
    launch(o, a, b);
    lat     = -1;
    its     = 0;
    alu_bad = 0;
    rh      = '0;
    rl      = '0;
    rz      = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (alu_own === 1'b1) begin
        its++;
        if (alu_control !== want_ctl) alu_bad++;
      end else if (alu_control !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
        alu_bad++;
      end
      if (busy !== 1'b1) alu_bad++;
      if (done === 1'b1) begin
        lat = c;
        rh  = hi;
        rl  = lo;
        rz  = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    rs_val = '0;
    rt_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, alu_own} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, done, div_by_zero, alu_own});
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 4'b0000) begin
      errors++;
      $display("FAIL reset_alu: got a=%h b=%h ctl=%b expected 0/0/0000", alu_a, alu_b, alu_control);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] t_rs [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h64, 32'h8000_0000};
    logic [31:0] t_rt [6] = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h64, 32'd0};
    logic [31:0] t_lo [6] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
    logic        t_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          lat, its, bad, exp_lat, exp_its;
    logic [31:0] rh, rl;
    logic        rz;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_rs[i], t_rt[i], lat, rh, rl, rz, its, bad);
      exp_lat = t_z[i] ? 2 : 35;
      exp_its = t_z[i] ? 0 : 32;
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat);
      end
      checks++;
      if (rh !== t_hi[i] || rl !== t_lo[i]) begin
        errors++;
        $display("FAIL dir%0d_hilo: got hi=%h lo=%h expected hi=%h lo=%h", i, rh, rl, t_hi[i], t_lo[i]);
      end
      checks++;
      if (rz !== t_z[i]) begin
        errors++;
        $display("FAIL dir%0d_dbz: got %b expected %b", i, rz, t_z[i]);
      end
      checks++;
      if (its != exp_its || bad != 0) begin
        errors++;
        $display("FAIL dir%0d_alu: got iters=%0d bad=%0d expected iters=%0d bad=0", i, its, bad, exp_its);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b, mh, ml, rh, rl;
    logic        mz, rz;
    int          lat, its, bad, exp_lat;
    for (int i = 0; i < 24; i++) begin
      o = 2'(i % 4);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 20);
        1:       b = -$urandom_range(1, 20);
        2:       b = (i == 10 || i == 15) ? 32'd0 : $urandom;
        default: b = $urandom;
      endcase
      if ((i % 5) == 0) a = $urandom_range(0, 1000);
      model(o, a, b, mh, ml, mz);
      run_op(o, a, b, lat, rh, rl, rz, its, bad);
      exp_lat = mz ? 2 : 35;
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL rnd%0d_latency: op=%0d got %0d expected %0d", i, o, lat, exp_lat);
      end
      checks++;
      if (rh !== mh || rl !== ml || rz !== mz) begin
        errors++;
        $display("FAIL rnd%0d_result: op=%0d rs=%h rt=%h got hi=%h lo=%h z=%b expected hi=%h lo=%h z=%b",
                 i, o, a, b, rh, rl, rz, mh, ml, mz);
      end
      checks++;
      if (bad != 0 || its != (mz ? 0 : 32)) begin
        errors++;
        $display("FAIL rnd%0d_alu: got iters=%0d bad=%0d expected iters=%0d bad=0", i, its, bad, mz ? 0 : 32);
      end
    end
  endtask

  // start at cycle 5 and in the DONE cycle (35) must be ignored
  task automatic test_start_ignored;
    int          n_done, lat;
    logic [31:0] rh, rl;
    n_done = 0;
    lat    = -1;
    rh     = '0;
    rl     = '0;
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) begin
          lat = c;
          rh  = hi;
          rl  = lo;
        end
      end
      start = (c == 5 || c == 35);
      if (c == 5) begin
        op     = 2'b11;
        rs_val = 32'h1234;
        rt_val = 32'd0;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 1 || lat != 35) begin
      errors++;
      $display("FAIL ignore_done: got count=%0d cycle=%0d expected count=1 cycle=35", n_done, lat);
    end
    checks++;
    if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL ignore_hilo: got hi=%h lo=%h expected hi=ffffffff lo=ffffffeb", rh, rl);
    end
    checks++;
    if (busy !== 1'b0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: got busy=%b dbz=%b expected 0/0", busy, div_by_zero);
    end
  endtask

  task automatic test_reset_mid;
    int          lat, its, bad, n_done;
    logic [31:0] rh, rl;
    logic        rz;
    run_op(2'b01, 32'd3, 32'd5, lat, rh, rl, rz, its, bad);
    checks++;
    if (rl !== 32'd15 || rh !== 32'd0) begin
      errors++;
      $display("FAIL rmid_pre: got hi=%h lo=%h expected hi=0 lo=f", rh, rl);
    end
    launch(2'b11, 32'h0000_FFFF, 32'd3);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL rmid_state: got busy=%b done=%b own=%b hi=%h lo=%h expected all 0",
               busy, done, alu_own, hi, lo);
    end
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL rmid_no_done: got %0d active cycles expected 0", n_done);
    end
  endtask

  // Second op started in the cycle after DONE; first results held until 71
  task automatic test_back_to_back;
    int          lat1, lat2, unstable;
    logic [31:0] h2, l2;
    lat1     = -1;
    lat2     = -1;
    unstable = 0;
    h2       = '0;
    l2       = '0;
    launch(2'b00, 32'hFFFF_FFFD, 32'd7);
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (lat1 < 0) lat1 = c;
        else if (lat2 < 0) begin
          lat2 = c;
          h2   = hi;
          l2   = lo;
        end
      end
      if (c >= 35 && c <= 70 && (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB)) unstable++;
      if (c == 36) begin
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd7;
      end
      start = (c == 36);
    end
    start = 1'b0;
    checks++;
    if (lat1 != 35 || lat2 != 71) begin
      errors++;
      $display("FAIL b2b_latency: got %0d/%0d expected 35/71", lat1, lat2);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL b2b_hold: got %0d cycles with changed hi/lo expected 0", unstable);
    end
    checks++;
    if (h2 !== 32'd2 || l2 !== 32'd14) begin
      errors++;
      $display("FAIL b2b_result: got hi=%h lo=%h expected hi=2 lo=e", h2, l2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
